// File: rtl/systolic_matmul_engine.sv
// Output-stationary NxN systolic matrix multiplier with start/done sequencing,
// internal operand skewing, valid/ready operand and result streams and runtime K.
module systolic_matmul_engine #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K_WIDTH-1:0]        k_len,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [N*DATA_WIDTH-1:0]   op_a,
  input  logic [N*DATA_WIDTH-1:0]   op_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(N)-1:0]      res_row,
  output logic [N*ACC_WIDTH-1:0]    res_data,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2*N-1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(N-1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [K_WIDTH-1:0]   klen_q, klen_d;
  logic [K_WIDTH-1:0]   beat_q, beat_d;
  logic [FW-1:0]        flush_q, flush_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 done_q, done_d;
  logic                 clear, accept, shift_en;

  assign accept   = (state_q == S_LOAD) && op_valid;
  assign shift_en = (state_q == S_LOAD) || (state_q == S_FLUSH);

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        clear   = 1'b1;
        klen_d  = k_len;
        beat_d  = '0;
        flush_d = '0;
        state_d = (k_len == '0) ? S_FLUSH : S_LOAD;
      end
      S_LOAD: if (accept) begin
        beat_d = beat_q + K_WIDTH'(1);
        if (beat_q == klen_q - K_WIDTH'(1)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = S_DRAIN;
          row_d   = '0;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      S_DRAIN: if (res_ready) begin
        if (row_q == LAST_ROW) begin
          state_d = S_IDLE;
          row_d   = '0;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Operands entering the array edges: skewed lane i / column j.
  logic signed [DATA_WIDTH-1:0] a_edge [N];
  logic signed [DATA_WIDTH-1:0] b_edge [N];
  logic signed [DATA_WIDTH-1:0] a_pe   [N][N];
  logic signed [DATA_WIDTH-1:0] b_pe   [N][N];
  logic signed [ACC_WIDTH-1:0]  acc_pe [N][N];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      logic signed [DATA_WIDTH-1:0] inj_a, inj_b;
      assign inj_a = accept ? op_a[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign inj_b = accept ? op_b[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gi == 0) begin : g_direct
        assign a_edge[gi] = inj_a;
        assign b_edge[gi] = inj_b;
      end else begin : g_delay
        logic signed [DATA_WIDTH-1:0] sa_q [gi];
        logic signed [DATA_WIDTH-1:0] sb_q [gi];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n || clear) begin
            for (int d = 0; d < gi; d++) begin
              sa_q[d] <= '0;
              sb_q[d] <= '0;
            end
          end else if (shift_en) begin
            sa_q[0] <= inj_a;
            sb_q[0] <= inj_b;
            for (int d = 1; d < gi; d++) begin
              sa_q[d] <= sa_q[d-1];
              sb_q[d] <= sb_q[d-1];
            end
          end
        end
        assign a_edge[gi] = sa_q[gi-1];
        assign b_edge[gi] = sb_q[gi-1];
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic signed [DATA_WIDTH-1:0]   a_in, b_in, a_q, b_q;
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [ACC_WIDTH-1:0]    acc_q;
        if (gj == 0) begin : g_al
          assign a_in = a_edge[gi];
        end else begin : g_ai
          assign a_in = a_pe[gi][gj-1];
        end
        if (gi == 0) begin : g_bt
          assign b_in = b_edge[gj];
        end else begin : g_bi
          assign b_in = b_pe[gi-1][gj];
        end
        assign prod = a_in * b_in;
        // Async reset and the start-time clear are folded into one branch.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n || clear) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
          end else if (shift_en) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_q + ACC_WIDTH'(prod);
          end
        end
        assign a_pe[gi][gj]   = a_q;
        assign b_pe[gi][gj]   = b_q;
        assign acc_pe[gi][gj] = acc_q;
      end
    end

    for (gj = 0; gj < N; gj++) begin : g_out
      assign res_data[gj*ACC_WIDTH +: ACC_WIDTH] =
        (state_q == S_DRAIN) ? acc_pe[row_q][gj] : '0;
    end
  endgenerate

  assign op_ready  = (state_q == S_LOAD);
  assign res_valid = (state_q == S_DRAIN);
  assign res_row   = row_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Scoreboard bench: N=2 identity check plus a series of N=4 jobs covering
// gaps, extreme values, k_len=0, result back-pressure and reset mid-drain.
module tb_systolic_matmul_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=4 instance
  logic         start4, opv4, opr4, resv4, resr4, busy4, done4;
  logic [15:0]  klen4;
  logic [31:0]  opa4, opb4;
  logic [1:0]   resrow4;
  logic [127:0] resdata4;

  // N=2 instance
  logic         start2, opv2, opr2, resv2, resr2, busy2, done2;
  logic [15:0]  klen2;
  logic [15:0]  opa2, opb2;
  logic [0:0]   resrow2;
  logic [63:0]  resdata2;

  systolic_matmul_engine #(.N(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .K_WIDTH(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .k_len(klen4),
    .op_valid(opv4), .op_ready(opr4), .op_a(opa4), .op_b(opb4),
    .res_valid(resv4), .res_ready(resr4), .res_row(resrow4), .res_data(resdata4),
    .busy(busy4), .done(done4)
  );

  systolic_matmul_engine #(.N(2), .DATA_WIDTH(8), .ACC_WIDTH(32), .K_WIDTH(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .k_len(klen2),
    .op_valid(opv2), .op_ready(opr2), .op_a(opa2), .op_b(opb2),
    .res_valid(resv2), .res_ready(resr2), .res_row(resrow2), .res_data(resdata2),
    .busy(busy2), .done(done2)
  );

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic [1:0]   row_q[$];
  logic [63:0]  exp2_q[$];

  int ma [4][16];
  int mb [16][4];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: all ones, 1: all -128, 2: A=-1 B=127, 3: random full range
  task automatic fill(input int mode, input int k);
    for (int i = 0; i < 4; i++) begin
      for (int kk = 0; kk < k; kk++) begin
        case (mode)
          0: begin ma[i][kk] = 1;    mb[kk][i] = 1;    end
          1: begin ma[i][kk] = -128; mb[kk][i] = -128; end
          2: begin ma[i][kk] = -1;   mb[kk][i] = 127;  end
          default: begin
            ma[i][kk] = int'($urandom_range(0, 255)) - 128;
            mb[kk][i] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    end
  endtask

  task automatic run_job4(input int k, input bit gappy, input int stall_row, input int abort_row);
    int beat, cyc, rows, dones, n, sum;
    bit stalled;
    logic [127:0] held, exp_d;
    logic [1:0]   exp_r;
    beat = 0; cyc = 0; rows = 0; dones = 0; stalled = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_d = '0;
      for (int j = 0; j < 4; j++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += ma[i][kk] * mb[kk][j];
        exp_d[j*32 +: 32] = 32'(sum);
      end
      exp_q.push_back(exp_d);
      row_q.push_back(2'(i));
    end

    @(negedge clk); start4 = 1'b1; klen4 = 16'(k);
    @(negedge clk); start4 = 1'b0;
    check_val("busy_start", 128'(busy4), 128'(1));

    while (beat < k && cyc < 200) begin
      if (gappy && (cyc % 2) == 1) begin
        opv4 = 1'b0;
      end else begin
        opv4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
          opa4[i*8 +: 8] = 8'(ma[i][beat]);
          opb4[i*8 +: 8] = 8'(mb[beat][i]);
        end
      end
      check_val("op_ready_load", 128'(opr4), 128'(1));
      if (opv4 && opr4) beat++;
      cyc++;
      @(negedge clk);
    end
    opv4 = 1'b0; opa4 = '0; opb4 = '0;
    if (beat < k) check_val("load_timeout", 128'(beat), 128'(k));

    n = 0;
    while (!resv4 && n < 50) begin
      check_val("op_ready_flush", 128'(opr4), 128'(0));
      n++;
      @(negedge clk);
    end
    check_val("flush_len", 128'(n), 128'(7));

    cyc = 0;
    while (rows < 4 && cyc < 100) begin
      cyc++;
      if (done4) dones++;
      if (resv4) begin
        if (int'(resrow4) == abort_row) begin
          rst_n = 1'b0;
          #1;
          check_val("rst_valid", 128'(resv4), 128'(0));
          check_val("rst_busy", 128'(busy4), 128'(0));
          check_val("rst_done", 128'(done4), 128'(0));
          exp_q.delete();
          row_q.delete();
          @(negedge clk); rst_n = 1'b1;
          repeat (3) begin
            @(negedge clk);
            check_val("no_done_after_rst", 128'(done4), 128'(0));
          end
          $display("job k=%0d aborted at row %0d", k, abort_row);
          return;
        end
        if (int'(resrow4) == stall_row && !stalled) begin
          resr4 = 1'b0;
          held = resdata4;
          stalled = 1'b1;
          repeat (5) begin
            @(negedge clk);
            check_val("stall_row", 128'(resrow4), 128'(stall_row));
            check_val("stall_data", resdata4, held);
            check_val("stall_valid", 128'(resv4), 128'(1));
          end
          resr4 = 1'b1;
        end
        exp_d = exp_q.pop_front();
        exp_r = row_q.pop_front();
        check_val("res_row", 128'(resrow4), 128'(exp_r));
        check_val("res_data", resdata4, exp_d);
        $display("k=%0d row %0d data %h", k, resrow4, resdata4);
        rows++;
      end
      @(negedge clk);
    end
    check_val("drain_rows", 128'(rows), 128'(4));
    check_val("drain_no_bubble", 128'(cyc), 128'(4));
    check_val("done_early", 128'(dones), 128'(0));
    check_val("done_pulse", 128'(done4), 128'(1));
    check_val("idle_busy", 128'(busy4), 128'(0));
    check_val("idle_valid", 128'(resv4), 128'(0));
    @(negedge clk);
    check_val("done_clear", 128'(done4), 128'(0));
  endtask

  int n2, d2;
  logic [63:0] e2;

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; klen4 = '0; opv4 = 1'b0; opa4 = '0; opb4 = '0; resr4 = 1'b1;
    start2 = 1'b0; klen2 = '0; opv2 = 1'b0; opa2 = '0; opb2 = '0; resr2 = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_op_ready", 128'(opr4), 128'(0));
    check_val("rst_res_valid", 128'(resv4), 128'(0));
    check_val("rst_res_row", 128'(resrow4), 128'(0));
    check_val("rst_res_data", resdata4, 128'(0));
    check_val("rst_busy4", 128'(busy4), 128'(0));
    check_val("rst_done4", 128'(done4), 128'(0));
    check_val("rst_busy2", 128'(busy2), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // N=2: A = I, B = [[1,2],[3,4]]
    start2 = 1'b1; klen2 = 16'd2;
    @(negedge clk); start2 = 1'b0;
    opv2 = 1'b1; opa2 = 16'h0001; opb2 = 16'h0201;
    exp2_q.push_back({32'd2, 32'd1});
    exp2_q.push_back({32'd4, 32'd3});
    @(negedge clk); opa2 = 16'h0100; opb2 = 16'h0403;
    @(negedge clk); opv2 = 1'b0; opa2 = '0; opb2 = '0;
    n2 = 0; d2 = 0;
    while (!resv2 && n2 < 20) begin
      if (done2) d2++;
      n2++;
      @(negedge clk);
    end
    check_val("n2_flush_len", 128'(n2), 128'(3));
    for (int r = 0; r < 2; r++) begin
      e2 = exp2_q.pop_front();
      check_val("n2_valid", 128'(resv2), 128'(1));
      check_val("n2_row", 128'(resrow2), 128'(r));
      check_val("n2_data", 128'(resdata2), 128'(e2));
      $display("n2 row %0d data %h", resrow2, resdata2);
      @(negedge clk);
    end
    check_val("n2_done", 128'(done2), 128'(1));
    @(negedge clk);
    check_val("n2_done_once", 128'(done2 + 1'b0) + 128'(d2), 128'(0));

    fill(0, 4); run_job4(4, 1'b1, -1, -1);
    fill(1, 3); run_job4(3, 1'b0, -1, -1);
    fill(2, 1); run_job4(1, 1'b0, -1, -1);
    run_job4(0, 1'b0, -1, -1);
    fill(3, 6); run_job4(6, 1'b0, 1, -1);
    fill(3, 5); run_job4(5, 1'b0, -1, 2);
    fill(3, 3); run_job4(3, 1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
